pot_controller: RTL

// Sequences the stove pot, one instance per stove tile. Accepts chopped onions deposited by the

---
 rtl/overcooked_pkg.sv | 35 +++
 rtl/key_debounce.sv | 35 +++
 rtl/pot_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/overcooked_pkg.sv
// overcooked_pkg
// Shared constants and types for the kitchen game logic: keyboard codes,
// tile identifiers, held-sprite indices and the pot state encoding seen by
// the onion module.
// Ports: none (package).
package overcooked_pkg;

  localparam logic [7:0] KEY_E = 8'h08;
  localparam logic [7:0] KEY_Q = 8'h14;

  typedef enum logic [3:0] {
    TILE_FLOOR   = 4'd0,
    TILE_WALL    = 4'd1,
    TILE_CRATE   = 4'd2,
    TILE_STOVE   = 4'd3,
    TILE_COUNTER = 4'd4,
    TILE_CUTTING = 4'd5,
    TILE_TRASH   = 4'd6
  } tile_t;

  typedef enum logic [2:0] {
    SPR_NONE  = 3'd0,
    SPR_ONION = 3'd3,
    SPR_PLATE = 3'd5
  } sprite_t;

  // bit0 low means the pot still accepts onions; DONE and BURNT share 11.
  typedef enum logic [1:0] {
    POT_EMPTY   = 2'b00,
    POT_FILLING = 2'b10,
    POT_COOKING = 2'b01,
    POT_READY   = 2'b11
  } pot_state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Turns a held keyboard code into spaced single-frame action requests.
// A frame counter counts up (saturating at 15) on every frame that does not
// fire; a frame where KEY is down and the count has reached DEBOUNCE fires
// and clears the count. Holding KEY therefore fires once every DEBOUNCE+1
// frames.
// Ports:
//   frame_clk  in   vsync clock
//   Reset      in   asynchronous, active-high
//   keycode    in   current keyboard code
//   fire       out  combinational: KEY pressed and spacing satisfied
module key_debounce #(
  parameter logic [7:0] KEY      = 8'h08,
  parameter int         DEBOUNCE = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       fire
);

  logic [3:0] dbCount;

  assign fire = (keycode == KEY) && (dbCount >= 4'(DEBOUNCE));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      dbCount <= '0;
    else if (fire)
      dbCount <= '0;
    else if (dbCount != 4'hF)
      dbCount <= dbCount + 4'd1;
  end

endmodule

// File: rtl/pot_controller.sv
// pot_controller
// Stove pot sequencer, one per stove tile. Takes chopped onions, cooks,
// then burns if left too long; the player serves onto a plate or dumps a
// burnt pot. All outputs are registered or decoded from registered state.
// Ports:
//   frame_clk, Reset        vsync clock, async active-high reset
//   keycode                 keyboard code (E = action)
//   wallFlag, tileType      penguin is at a counter and facing this stove
//   heldSpriteIndexIn       what the penguin holds (none/onion/plate)
//   onionChopped            held onion is chopped
//   potState                pot encoding for the onion module
//   potOnionPresent         pot holds at least one onion
//   onionCount              onions in the pot
//   cookProgress            cook quarter elapsed (3 once cooked)
//   burnt                   pot is burnt
//   onionTaken, soupServed, potDumped   one-frame event pulses
//
// state     | meaning
// S_EMPTY   | no onions, idle
// S_FILLING | some onions, waiting for more
// S_COOKING | full, cook timer running, keys ignored
// S_DONE    | soup ready, burn timer running
// S_BURNT   | soup ruined, must be dumped empty-handed
module pot_controller
  import overcooked_pkg::*;
#(
  parameter int ONIONS_PER_SOUP = 3,
  parameter int COOK_FRAMES     = 300,
  parameter int BURN_FRAMES     = 420,
  parameter int TIMER_BITS      = 10,
  parameter int DEBOUNCE        = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       wallFlag,
  input  logic [3:0] tileType,
  input  logic [2:0] heldSpriteIndexIn,
  input  logic       onionChopped,
  output logic [1:0] potState,
  output logic       potOnionPresent,
  output logic [2:0] onionCount,
  output logic [1:0] cookProgress,
  output logic       burnt,
  output logic       onionTaken,
  output logic       soupServed,
  output logic       potDumped
);

  typedef enum logic [2:0] {S_EMPTY, S_FILLING, S_COOKING, S_DONE, S_BURNT} state_t;

  localparam logic [TIMER_BITS-1:0] TIMER_ONE = TIMER_BITS'(1);
  localparam logic [TIMER_BITS-1:0] COOK_LAST = TIMER_BITS'(COOK_FRAMES - 1);
  localparam logic [TIMER_BITS-1:0] BURN_LAST = TIMER_BITS'(BURN_FRAMES - 1);
  localparam logic [TIMER_BITS-1:0] COOK_Q1   = TIMER_BITS'(COOK_FRAMES * 1 / 4);
  localparam logic [TIMER_BITS-1:0] COOK_Q2   = TIMER_BITS'(COOK_FRAMES * 2 / 4);
  localparam logic [TIMER_BITS-1:0] COOK_Q3   = TIMER_BITS'(COOK_FRAMES * 3 / 4);
  localparam logic [2:0]            FULL      = 3'(ONIONS_PER_SOUP);

  state_t                state, state_n;
  logic [2:0]            count_n;
  logic [TIMER_BITS-1:0] timer, timer_n;
  logic                  taken_n, served_n, dumped_n;
  logic                  keyFire, act;

  key_debounce #(.KEY(KEY_E), .DEBOUNCE(DEBOUNCE)) u_key_e (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .fire      (keyFire)
  );

  assign act = keyFire && wallFlag && (tileType == TILE_STOVE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_EMPTY;
      onionCount <= '0;
      timer      <= '0;
      onionTaken <= 1'b0;
      soupServed <= 1'b0;
      potDumped  <= 1'b0;
    end else begin
      state      <= state_n;
      onionCount <= count_n;
      timer      <= timer_n;
      onionTaken <= taken_n;
      soupServed <= served_n;
      potDumped  <= dumped_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = onionCount;
    timer_n  = timer;
    taken_n  = 1'b0;
    served_n = 1'b0;
    dumped_n = 1'b0;
    case (state)
      S_EMPTY, S_FILLING: begin
        if (act && heldSpriteIndexIn == SPR_ONION && onionChopped && onionCount < FULL) begin
          count_n = onionCount + 3'd1;
          taken_n = 1'b1;
          if (count_n == FULL) begin
            state_n = S_COOKING;
            timer_n = '0;
          end else begin
            state_n = S_FILLING;
          end
        end
      end
      S_COOKING: begin
        if (timer == COOK_LAST) begin
          state_n = S_DONE;
          timer_n = '0;
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      S_DONE: begin
        // serving wins over burning on the same frame
        if (act && heldSpriteIndexIn == SPR_PLATE) begin
          served_n = 1'b1;
          state_n  = S_EMPTY;
          count_n  = '0;
          timer_n  = '0;
        end else if (timer == BURN_LAST) begin
          state_n = S_BURNT;
          timer_n = '0;
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      S_BURNT: begin
        if (act && heldSpriteIndexIn == SPR_NONE) begin
          dumped_n = 1'b1;
          state_n  = S_EMPTY;
          count_n  = '0;
          timer_n  = '0;
        end
      end
      default: begin
        state_n = S_EMPTY;
        count_n = '0;
        timer_n = '0;
      end
    endcase
  end

  always_comb begin
    potState     = POT_EMPTY;
    cookProgress = 2'd0;
    case (state)
      S_FILLING: potState = POT_FILLING;
      S_COOKING: begin
        potState     = POT_COOKING;
        cookProgress = 2'((timer >= COOK_Q1)) + 2'((timer >= COOK_Q2)) + 2'((timer >= COOK_Q3));
      end
      S_DONE, S_BURNT: begin
        potState     = POT_READY;
        cookProgress = 2'd3;
      end
      default: potState = POT_EMPTY;
    endcase
  end

  assign potOnionPresent = (onionCount != 3'd0);
  assign burnt           = (state == S_BURNT);

endmodule
